alu_issue: RTL and testbench

Command front end for the 4-bit combinational ALU. Buffers operand/opcode commands in a small FIFO and drives them one at a time onto the ALU inputs. Holds each command stable for a full cycle, samples the ALU outputs, and returns the registered result and flags on a valid/ready response port. Sits directly upstream of the ALU and is the only driver of its `in_a`/`in_b`/`sel`.

---
 rtl/alu_pkg.sv | 31 +++
 rtl/cmd_fifo.sv | 61 ++++++
 rtl/alu_issue.sv | 143 ++++++++++++++
 tb/tb_alu_issue.sv | 269 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/alu_pkg.sv
// Shared definitions for the ALU command front end: opcodes, FSM states, widths.
// Latency: n/a (package only).
// Backpressure: n/a (package only).
package alu_pkg;

  localparam int ALU_W  = 4;
  localparam int OP_W   = 3;
  localparam int CMD_W  = OP_W + 2 * ALU_W;  // {op, a, b}

  localparam logic [OP_W-1:0] ALU_ADD = 3'b000;
  localparam logic [OP_W-1:0] ALU_SUB = 3'b001;
  localparam logic [OP_W-1:0] ALU_NOT = 3'b010;
  localparam logic [OP_W-1:0] ALU_AND = 3'b011;
  localparam logic [OP_W-1:0] ALU_OR  = 3'b100;
  localparam logic [OP_W-1:0] ALU_XOR = 3'b101;
  localparam logic [OP_W-1:0] ALU_LT  = 3'b110;
  localparam logic [OP_W-1:0] ALU_EQ  = 3'b111;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ISSUE = 2'd1,
    ST_RESP  = 2'd2
  } issue_state_e;

  // Only add and subtract produce meaningful carry/overflow; every other
  // opcode reports them as zero regardless of what the ALU drives.
  function automatic logic has_arith_flags(input logic [OP_W-1:0] op);
    return (op == ALU_ADD) || (op == ALU_SUB);
  endfunction

endpackage

// File: rtl/cmd_fifo.sv
// Synchronous command FIFO; head is the oldest entry, shown combinationally from storage.
// Latency: a push is visible at head/count the cycle after the push edge.
// Backpressure: push is ignored when full and pop when empty; the caller gates on full/empty.
// Ports: clk, rst_n; push/push_dat write side; pop/head read side; count, full, empty status.
module cmd_fifo #(
  parameter int DEPTH = 4,
  parameter int W     = 11,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic          clk,
  input  logic          rst_n,
  input  logic          push,
  input  logic [W-1:0]  push_dat,
  input  logic          pop,
  output logic [W-1:0]  head,
  output logic [CW-1:0] count,
  output logic          full,
  output logic          empty
);

  localparam int AW = $clog2(DEPTH);

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_ptr_q;
  logic [AW-1:0] rd_ptr_q;
  logic [CW-1:0] count_q;
  logic          push_en;
  logic          pop_en;

  assign full    = (count_q == CW'(DEPTH));
  assign empty   = (count_q == '0);
  assign push_en = push && !full;
  assign pop_en  = pop && !empty;
  assign head    = mem_q[rd_ptr_q];
  assign count   = count_q;

  // Storage needs no reset: an entry is only read after it has been written.
  always_ff @(posedge clk) begin
    if (push_en) begin
      mem_q[wr_ptr_q] <= push_dat;
    end
  end

  // DEPTH is a power of two, so pointers wrap naturally.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (push_en) wr_ptr_q <= wr_ptr_q + AW'(1);
      if (pop_en)  rd_ptr_q <= rd_ptr_q + AW'(1);
      case ({push_en, pop_en})
        2'b10:   count_q <= count_q + CW'(1);
        2'b01:   count_q <= count_q - CW'(1);
        default: count_q <= count_q;
      endcase
    end
  end

endmodule

// File: rtl/alu_issue.sv
// Command front end for the 4-bit combinational ALU: queues commands, issues one at a time, returns result+flags.
// Latency: command accepted at edge T into an idle block -> alu_* after T+1 -> rsp_valid after T+2; 2 cycles/response.
// Backpressure: cmd_ready drops when the queue is full; a stalled response holds all rsp_* until rsp_ready.
// Ports: cmd_valid/cmd_ready/cmd_a/cmd_b/cmd_op in; alu_a/alu_b/alu_sel out, alu_res/alu_c/alu_of in;
//        rsp_valid/rsp_ready/rsp_res/rsp_op/rsp_c/rsp_z/rsp_of out; count = queue occupancy.
module alu_issue
  import alu_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int CW    = $clog2(DEPTH + 1)
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [ALU_W-1:0] cmd_a,
  input  logic [ALU_W-1:0] cmd_b,
  input  logic [OP_W-1:0]  cmd_op,
  output logic [ALU_W-1:0] alu_a,
  output logic [ALU_W-1:0] alu_b,
  output logic [OP_W-1:0]  alu_sel,
  input  logic [ALU_W-1:0] alu_res,
  input  logic             alu_c,
  input  logic             alu_of,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [ALU_W-1:0] rsp_res,
  output logic [OP_W-1:0]  rsp_op,
  output logic             rsp_c,
  output logic             rsp_z,
  output logic             rsp_of,
  output logic [CW-1:0]    count
);

  issue_state_e     state_q;
  logic [ALU_W-1:0] alu_a_q;
  logic [ALU_W-1:0] alu_b_q;
  logic [OP_W-1:0]  alu_sel_q;
  logic             rsp_valid_q;
  logic [ALU_W-1:0] rsp_res_q;
  logic [OP_W-1:0]  rsp_op_q;
  logic             rsp_c_q;
  logic             rsp_z_q;
  logic             rsp_of_q;

  logic [CMD_W-1:0] push_dat;
  logic [CMD_W-1:0] head;
  logic             fifo_full;
  logic             fifo_empty;
  logic             fifo_push;
  logic             fifo_pop;
  logic [OP_W-1:0]  head_op;
  logic [ALU_W-1:0] head_a;
  logic [ALU_W-1:0] head_b;

  // Ready depends only on registered occupancy, so a same-cycle pop never
  // opens a slot until the following cycle.
  assign cmd_ready = !fifo_full;
  assign fifo_push = cmd_valid && cmd_ready;
  assign push_dat  = {cmd_op, cmd_a, cmd_b};
  // The entry stays in the queue while it is on the ALU and leaves as its
  // result is captured.
  assign fifo_pop  = (state_q == ST_ISSUE);
  assign {head_op, head_a, head_b} = head;

  cmd_fifo #(
    .DEPTH (DEPTH),
    .W     (CMD_W),
    .CW    (CW)
  ) u_cmd_fifo (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (fifo_push),
    .push_dat (push_dat),
    .pop      (fifo_pop),
    .head     (head),
    .count    (count),
    .full     (fifo_full),
    .empty    (fifo_empty)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= ST_IDLE;
      alu_a_q     <= '0;
      alu_b_q     <= '0;
      alu_sel_q   <= '0;
      rsp_valid_q <= 1'b0;
      rsp_res_q   <= '0;
      rsp_op_q    <= '0;
      rsp_c_q     <= 1'b0;
      rsp_z_q     <= 1'b0;
      rsp_of_q    <= 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (!fifo_empty) begin
            alu_a_q   <= head_a;
            alu_b_q   <= head_b;
            alu_sel_q <= head_op;
            state_q   <= ST_ISSUE;
          end
        end
        ST_ISSUE: begin
          // Operands have been stable on the ALU for a full cycle here.
          rsp_res_q   <= alu_res;
          rsp_op_q    <= alu_sel_q;
          rsp_z_q     <= (alu_res == '0);
          rsp_c_q     <= has_arith_flags(alu_sel_q) ? alu_c  : 1'b0;
          rsp_of_q    <= has_arith_flags(alu_sel_q) ? alu_of : 1'b0;
          rsp_valid_q <= 1'b1;
          state_q     <= ST_RESP;
        end
        ST_RESP: begin
          if (rsp_valid_q && rsp_ready) begin
            rsp_valid_q <= 1'b0;
            // Occupancy here already reflects the pop taken in ISSUE.
            if (!fifo_empty) begin
              alu_a_q   <= head_a;
              alu_b_q   <= head_b;
              alu_sel_q <= head_op;
              state_q   <= ST_ISSUE;
            end else begin
              state_q   <= ST_IDLE;
            end
          end
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  assign alu_a     = alu_a_q;
  assign alu_b     = alu_b_q;
  assign alu_sel   = alu_sel_q;
  assign rsp_valid = rsp_valid_q;
  assign rsp_res   = rsp_res_q;
  assign rsp_op    = rsp_op_q;
  assign rsp_c     = rsp_c_q;
  assign rsp_z     = rsp_z_q;
  assign rsp_of    = rsp_of_q;

endmodule

// File: tb/tb_alu_issue.sv
module tb_alu_issue;
  import alu_pkg::*;

  localparam int DEPTH = 4;
  localparam int CW    = $clog2(DEPTH + 1);

  logic          clk;
  logic          rst_n;
  logic          cmd_valid;
  logic          cmd_ready;
  logic [3:0]    cmd_a, cmd_b;
  logic [2:0]    cmd_op;
  logic [3:0]    alu_a, alu_b;
  logic [2:0]    alu_sel;
  logic [3:0]    alu_res;
  logic          alu_c, alu_of;
  logic          rsp_valid, rsp_ready;
  logic [3:0]    rsp_res;
  logic [2:0]    rsp_op;
  logic          rsp_c, rsp_z, rsp_of;
  logic [CW-1:0] count;

  int total = 0;
  int bad   = 0;
  int n_rsp = 0;
  logic c_force = 1'b0;

  alu_issue #(.DEPTH(DEPTH), .CW(CW)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready),
    .cmd_a(cmd_a), .cmd_b(cmd_b), .cmd_op(cmd_op),
    .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
    .alu_res(alu_res), .alu_c(alu_c), .alu_of(alu_of),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_res(rsp_res), .rsp_op(rsp_op),
    .rsp_c(rsp_c), .rsp_z(rsp_z), .rsp_of(rsp_of),
    .count(count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference ALU: returns {c, of, res}. Non-arithmetic ops drive junk flags
  // so that the front end's masking of carry/overflow is observable.
  function automatic logic [5:0] alu_fn(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op);
    logic [4:0] s;
    logic [3:0] r;
    logic       c, of;
    c  = ^a;
    of = ^b;
    r  = 4'h0;
    s  = 5'h0;
    case (op)
      3'd0: begin s = {1'b0, a} + {1'b0, b}; r = s[3:0]; c = s[4]; of = (a[3] == b[3]) && (r[3] != a[3]); end
      3'd1: begin s = {1'b0, a} - {1'b0, b}; r = s[3:0]; c = s[4]; of = (a[3] != b[3]) && (r[3] != a[3]); end
      3'd2: r = ~a;
      3'd3: r = a & b;
      3'd4: r = a | b;
      3'd5: r = a ^ b;
      3'd6: r = (a < b) ? 4'd1 : 4'd0;
      default: r = (a == b) ? 4'd1 : 4'd0;
    endcase
    return {c, of, r};
  endfunction

  logic [5:0] alu_f;
  always_comb begin
    alu_f   = alu_fn(alu_a, alu_b, alu_sel);
    alu_res = alu_f[3:0];
    alu_of  = alu_f[4];
    alu_c   = alu_f[5] | c_force;
  end

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
    end
  endtask

  // ---------------- scoreboard / compare process ----------------
  typedef struct {
    logic [3:0] a;
    logic [3:0] b;
    logic [2:0] op;
  } cmd_t;

  cmd_t exp_q[$];
  cmd_t cur;
  bit   have_cur = 0;
  bit   prev_pend = 0;

  always @(negedge clk) begin
    logic [5:0] f;
    logic [3:0] e_res;
    if (!rst_n) begin
      exp_q.delete();
      have_cur  = 0;
      prev_pend = 0;
    end else begin
      if (prev_pend) chk("rsp_hold", rsp_valid, 1'b1);
      if (rsp_valid) begin
        if (!have_cur) begin
          if (exp_q.size() == 0) begin
            total++;
            bad++;
            $display("FAIL spurious_rsp: got rsp_res=%0h rsp_op=%0h with no command outstanding at %0t",
                     rsp_res, rsp_op, $time);
          end else begin
            cur = exp_q.pop_front();
            have_cur = 1;
            n_rsp++;
          end
        end
        if (have_cur) begin
          f     = alu_fn(cur.a, cur.b, cur.op);
          e_res = f[3:0];
          chk("rsp_res", rsp_res, e_res);
          chk("rsp_op",  rsp_op,  cur.op);
          chk("rsp_z",   rsp_z,   e_res == 4'h0);
          chk("rsp_c",   rsp_c,   (cur.op <= 3'd1) ? f[5] : 1'b0);
          chk("rsp_of",  rsp_of,  (cur.op <= 3'd1) ? f[4] : 1'b0);
        end
        prev_pend = !rsp_ready;
        if (rsp_ready) have_cur = 0;
      end else begin
        prev_pend = 0;
      end
      // Queue occupancy = commands pushed whose response has not yet begun.
      chk("count_model", count, exp_q.size());
      chk("count_max", count <= DEPTH, 1'b1);
      chk("cmd_ready_rule", cmd_ready, count != DEPTH);
      if (cmd_valid && cmd_ready) exp_q.push_back('{cmd_a, cmd_b, cmd_op});
    end
  end

  // ---------------- directed helpers ----------------
  // Single command into an idle, empty block with exact latency checks.
  task automatic do_one(input logic [3:0] a, input logic [3:0] b, input logic [2:0] op,
                        input logic [3:0] er, input logic ez, input logic ec, input logic eof);
    cmd_a = a; cmd_b = b; cmd_op = op; cmd_valid = 1'b1; rsp_ready = 1'b1;
    @(posedge clk); #1;            // edge T: accepted
    cmd_valid = 1'b0;
    @(posedge clk); #1;            // after T+1
    chk("lat1_alu_a",   alu_a,   a);
    chk("lat1_alu_b",   alu_b,   b);
    chk("lat1_alu_sel", alu_sel, op);
    chk("lat1_rsp_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;            // after T+2
    chk("lat2_rsp_valid", rsp_valid, 1'b1);
    chk("lat2_rsp_res", rsp_res, er);
    chk("lat2_rsp_op",  rsp_op,  op);
    chk("lat2_rsp_z",   rsp_z,   ez);
    chk("lat2_rsp_c",   rsp_c,   ec);
    chk("lat2_rsp_of",  rsp_of,  eof);
    @(posedge clk); #1;            // accepted
    chk("after_acc_valid", rsp_valid, 1'b0);
    @(posedge clk); #1;
  endtask

  task automatic drain(input string nm);
    bit done;
    done = 0;
    cmd_valid = 1'b0;
    rsp_ready = 1'b1;
    for (int k = 0; k < 200 && !done; k++) begin
      @(posedge clk); #1;
      if (count == 0 && !rsp_valid) done = 1;
    end
    chk(nm, done, 1'b1);
  endtask

  logic [3:0] st_a  [5] = '{4'd2, 4'd9, 4'd6, 4'hC, 4'd3};
  logic [3:0] st_b  [5] = '{4'd3, 4'd4, 4'd0, 4'hA, 4'd3};
  logic [2:0] st_op [5] = '{3'd0, 3'd1, 3'd2, 3'd4, 3'd7};

  initial begin
    int n0;
    rst_n = 1'b0; cmd_valid = 1'b0; cmd_a = '0; cmd_b = '0; cmd_op = '0; rsp_ready = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_rsp_valid", rsp_valid, 1'b0);
    chk("rst_alu_sel",   alu_sel,   3'b000);
    chk("rst_count",     count,     0);
    chk("rst_cmd_ready", cmd_ready, 1'b1);
    rst_n = 1'b1;
    @(posedge clk); #1;

    // Basic vectors (hand-computed)
    do_one(4'd3, 4'd4, ALU_ADD, 4'd7, 1'b0, 1'b0, 1'b0);
    do_one(4'd5, 4'd5, ALU_SUB, 4'd0, 1'b1, 1'b0, 1'b0);
    do_one(4'd7, 4'd1, ALU_ADD, 4'd8, 1'b0, 1'b0, 1'b1);
    c_force = 1'b1;
    do_one(4'hF, 4'h0, ALU_AND, 4'd0, 1'b1, 1'b0, 1'b0);
    c_force = 1'b0;
    do_one(4'hC, 4'hA, ALU_XOR, 4'h6, 1'b0, 1'b0, 1'b0);

    // Stall: 5 commands with the consumer blocked
    rsp_ready = 1'b0;
    n0 = n_rsp;
    for (int i = 0; i < 5; i++) begin
      cmd_a = st_a[i]; cmd_b = st_b[i]; cmd_op = st_op[i]; cmd_valid = 1'b1;
      @(posedge clk); #1;
    end
    cmd_valid = 1'b0;
    repeat (3) begin @(posedge clk); #1; end
    chk("stall_count",     count,     4);
    chk("stall_cmd_ready", cmd_ready, 1'b0);
    chk("stall_rsp_valid", rsp_valid, 1'b1);
    chk("stall_rsp_res",   rsp_res,   4'd5);
    chk("stall_rsp_op",    rsp_op,    3'd0);
    drain("stall_drain");
    chk("stall_rsp_cnt", n_rsp - n0, 5);

    // Streaming random traffic
    for (int cyc = 0; cyc < 200; cyc++) begin
      cmd_valid = 1'($urandom_range(0, 1));
      cmd_a     = 4'($urandom_range(0, 15));
      cmd_b     = 4'($urandom_range(0, 15));
      cmd_op    = 3'($urandom_range(0, 7));
      rsp_ready = 1'($urandom_range(0, 1));
      @(posedge clk); #1;
    end
    drain("stream_drain");
    chk("stream_no_leftover", exp_q.size(), 0);

    // Reset while a command is in ISSUE with 3 queued
    rsp_ready = 1'b0;
    cmd_a = 4'd1; cmd_b = 4'd1; cmd_op = ALU_ADD; cmd_valid = 1'b1;
    @(posedge clk); #1;
    cmd_a = 4'd6; cmd_b = 4'd3; cmd_op = ALU_XOR;
    @(posedge clk); #1;
    cmd_a = 4'd2; cmd_b = 4'd2; cmd_op = ALU_OR;
    @(posedge clk); #1;
    cmd_a = 4'd9; cmd_b = 4'd1; cmd_op = ALU_SUB;
    @(posedge clk); #1;
    cmd_valid = 1'b0;
    @(posedge clk); #1;
    chk("pre_rst_count", count, 3);
    rsp_ready = 1'b1;
    @(posedge clk); #1;            // accept -> next command issued
    chk("pre_rst_alu_sel", alu_sel, ALU_XOR);
    chk("pre_rst_alu_a",   alu_a,   4'd6);
    rst_n = 1'b0;
    #1;
    chk("arst_count",     count,     0);
    chk("arst_rsp_valid", rsp_valid, 1'b0);
    chk("arst_cmd_ready", cmd_ready, 1'b1);
    chk("arst_alu_sel",   alu_sel,   3'b000);
    chk("arst_alu_a",     alu_a,     4'd0);
    @(posedge clk); #1;
    rst_n = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    chk("post_rst_count",     count,     0);
    chk("post_rst_rsp_valid", rsp_valid, 1'b0);
    do_one(4'd1, 4'd2, ALU_ADD, 4'd3, 1'b0, 1'b0, 1'b0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1, "watchdog");
  end

endmodule
